// File: rtl/mif_pkg.sv
// Shared constants and the routing tag for the memory-interface crossbar.
// The localparams are the reference configuration; mif_xbar parameters default to them.
package mif_pkg;

  localparam int POOL_CORE_DEF      = 6;
  localparam int NUM_PORT_DEF       = 2;
  localparam int POOL_COMP_CORE_DEF = 64;
  localparam int ACT_WIDTH_DEF      = 8;
  localparam int IDX_WIDTH_DEF      = 10;
  localparam int TAG_DEPTH_DEF      = 4;

  localparam int FM_W   = ACT_WIDTH_DEF * POOL_COMP_CORE_DEF;
  localparam int CORE_W = (POOL_CORE_DEF > 1) ? $clog2(POOL_CORE_DEF) : 1;
  localparam int PORT_W = (NUM_PORT_DEF > 1) ? $clog2(NUM_PORT_DEF) : 1;

  // One outstanding read: which core issued it and the address it asked for.
  typedef struct packed {
    logic [CORE_W-1:0]        core;
    logic [IDX_WIDTH_DEF-1:0] addr;
  } tag_t;

endpackage

// File: rtl/mif_port.sv
// One GLB read port: round-robin request arbiter, outgoing address register,
// and the in-order tag FIFO that remembers who asked for each pending word.
module mif_port
  import mif_pkg::*;
#(
  parameter int POOL_CORE = POOL_CORE_DEF,
  parameter int IDX_WIDTH = IDX_WIDTH_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [POOL_CORE-1:0]           req_vld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0] req_addr,
  output logic [POOL_CORE-1:0]           req_rdy,
  output logic                           glb_addr_vld,
  output logic [IDX_WIDTH-1:0]           glb_addr,
  input  logic                           glb_addr_rdy,
  input  logic                           tag_pop,
  output logic                           tag_empty,
  output tag_t                           tag_head
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  logic [CORE_W-1:0]    rr_ptr;
  logic [CORE_W-1:0]    grant_idx;
  logic                 found;
  logic                 grant;
  logic                 can_grant;
  logic                 tag_full;
  logic                 pop;
  logic [IDX_WIDTH-1:0] sel_addr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  tag_t                 mem [TAG_DEPTH];

  assign tag_full  = (count == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count == '0);
  assign pop       = tag_pop && !tag_empty;
  // A pop in the same cycle does not free a slot for a push; only a truly non-full FIFO accepts.
  assign can_grant = !tag_full && (!glb_addr_vld || glb_addr_rdy);
  assign tag_head  = mem[rd_ptr];

  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < POOL_CORE; i++) begin
      idx = (int'(rr_ptr) + i) % POOL_CORE;
      if (!found && req_vld[idx]) begin
        found     = 1'b1;
        grant_idx = CORE_W'(idx);
      end
    end
    grant    = found && can_grant;
    sel_addr = req_addr[int'(grant_idx)*IDX_WIDTH +: IDX_WIDTH];
    req_rdy  = '0;
    if (grant) req_rdy[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      glb_addr_vld <= 1'b0;
      glb_addr     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
    end else begin
      if (grant) begin
        rr_ptr       <= (grant_idx == CORE_W'(POOL_CORE - 1)) ? '0 : grant_idx + CORE_W'(1);
        glb_addr_vld <= 1'b1;
        glb_addr     <= sel_addr;
        wr_ptr       <= (wr_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end else if (glb_addr_rdy) begin
        glb_addr_vld <= 1'b0;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage only; occupancy is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (grant) mem[wr_ptr] <= '{core: grant_idx, addr: sel_addr};
  end

endmodule

// File: rtl/mif_xbar.sv
// Crossbar between pooling cores and GLB read ports: address high bits pick the port,
// per-port tag FIFOs steer returned feature words into per-core output registers.
module mif_xbar
  import mif_pkg::*;
#(
  parameter int POOL_CORE      = POOL_CORE_DEF,
  parameter int NUM_PORT       = NUM_PORT_DEF,
  parameter int POOL_COMP_CORE = POOL_COMP_CORE_DEF,
  parameter int ACT_WIDTH      = ACT_WIDTH_DEF,
  parameter int IDX_WIDTH      = IDX_WIDTH_DEF,
  parameter int TAG_DEPTH      = TAG_DEPTH_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [POOL_CORE-1:0]                        POLMIF_AddrVld,
  input  logic [IDX_WIDTH*POOL_CORE-1:0]              POLMIF_Addr,
  output logic [POOL_CORE-1:0]                        MIFPOL_AddrRdy,
  output logic [NUM_PORT-1:0]                         MIFGLB_AddrVld,
  output logic [IDX_WIDTH*NUM_PORT-1:0]               MIFGLB_Addr,
  input  logic [NUM_PORT-1:0]                         GLBMIF_AddrRdy,
  input  logic [ACT_WIDTH*POOL_COMP_CORE*NUM_PORT-1:0]  GLBMIF_Fm,
  input  logic [NUM_PORT-1:0]                         GLBMIF_FmVld,
  output logic [NUM_PORT-1:0]                         MIFGLB_FmRdy,
  output logic [ACT_WIDTH*POOL_COMP_CORE*POOL_CORE-1:0] MIFPOL_Fm,
  output logic [IDX_WIDTH*POOL_CORE-1:0]              MIFPOL_FmAddr,
  output logic [POOL_CORE-1:0]                        MIFPOL_FmVld,
  input  logic [POOL_CORE-1:0]                        POLMIF_FmRdy,
  output logic                                        MIFCTR_Idle
);

  localparam int FMW    = ACT_WIDTH * POOL_COMP_CORE;
  localparam int PSEL_W = $clog2(NUM_PORT);

  // Every channel uses valid/ready: a transfer happens on a clock edge where both are high;
  // a source holds its payload stable while valid is high and ready is low.

  logic [PORT_W-1:0]    core_port [POOL_CORE];
  logic [POOL_CORE-1:0] port_req  [NUM_PORT];
  logic [POOL_CORE-1:0] port_rdy  [NUM_PORT];
  logic [NUM_PORT-1:0]  tag_empty;
  tag_t                 tag_head  [NUM_PORT];
  logic [POOL_CORE-1:0] core_free;
  logic [POOL_CORE-1:0] core_load;
  logic [FMW-1:0]       load_fm   [POOL_CORE];
  logic [IDX_WIDTH-1:0] load_addr [POOL_CORE];

  for (genvar c = 0; c < POOL_CORE; c++) begin : g_sel
    if (NUM_PORT == 1) begin : g_one
      assign core_port[c] = '0;
    end else begin : g_hi
      assign core_port[c] = POLMIF_Addr[c*IDX_WIDTH + IDX_WIDTH - 1 -: PSEL_W];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      for (int c = 0; c < POOL_CORE; c++) begin
        port_req[p][c] = POLMIF_AddrVld[c] && (core_port[c] == PORT_W'(p));
      end
    end
  end

  always_comb begin
    MIFPOL_AddrRdy = '0;
    for (int p = 0; p < NUM_PORT; p++) MIFPOL_AddrRdy = MIFPOL_AddrRdy | port_rdy[p];
  end

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    mif_port #(
      .POOL_CORE (POOL_CORE),
      .IDX_WIDTH (IDX_WIDTH),
      .TAG_DEPTH (TAG_DEPTH)
    ) u_port (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_vld      (port_req[p]),
      .req_addr     (POLMIF_Addr),
      .req_rdy      (port_rdy[p]),
      .glb_addr_vld (MIFGLB_AddrVld[p]),
      .glb_addr     (MIFGLB_Addr[p*IDX_WIDTH +: IDX_WIDTH]),
      .glb_addr_rdy (GLBMIF_AddrRdy[p]),
      .tag_pop      (MIFGLB_FmRdy[p]),
      .tag_empty    (tag_empty[p]),
      .tag_head     (tag_head[p])
    );
  end

  assign core_free = ~MIFPOL_FmVld | POLMIF_FmRdy;

  // Ports are scanned lowest first, so the lowest index wins a contested core register.
  always_comb begin
    MIFGLB_FmRdy = '0;
    core_load    = '0;
    for (int c = 0; c < POOL_CORE; c++) begin
      load_fm[c]   = '0;
      load_addr[c] = '0;
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      for (int c = 0; c < POOL_CORE; c++) begin
        if (GLBMIF_FmVld[p] && !tag_empty[p] && (tag_head[p].core == CORE_W'(c)) &&
            core_free[c] && !core_load[c]) begin
          MIFGLB_FmRdy[p] = 1'b1;
          core_load[c]    = 1'b1;
          load_fm[c]      = GLBMIF_Fm[p*FMW +: FMW];
          load_addr[c]    = tag_head[p].addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      MIFPOL_FmVld  <= '0;
      MIFPOL_Fm     <= '0;
      MIFPOL_FmAddr <= '0;
    end else begin
      for (int c = 0; c < POOL_CORE; c++) begin
        if (core_load[c]) begin
          MIFPOL_FmVld[c]                        <= 1'b1;
          MIFPOL_Fm[c*FMW +: FMW]                <= load_fm[c];
          MIFPOL_FmAddr[c*IDX_WIDTH +: IDX_WIDTH] <= load_addr[c];
        end else if (POLMIF_FmRdy[c]) begin
          MIFPOL_FmVld[c] <= 1'b0;
        end
      end
    end
  end

  assign MIFCTR_Idle = (&tag_empty) && !(|MIFPOL_FmVld);

endmodule
